spi_target: RTL and testbench
=============================

SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 SHALL have parameter IdleByte, default 8'hFF, the byte shifted out on CIPO when no transmit data is held.
REQ-002 SHALL have parameter SyncStages, default 2, the synchroniser depth on SPI pin inputs (legal range 2-3).
REQ-003 SHALL have port clk_sys_i, input, 1, system clock; the block's only clock.
REQ-004 SHALL have port rst_sys_ni, input, 1, reset, synchronous to clk_sys_i and active-low.
REQ-005 SHALL have port spi_sclk_i, input, 1, SPI clock from an external controller, asynchronous to clk_sys_i.
REQ-006 SHALL have port spi_cs_ni, input, 1, chip select, active-low, asynchronous.
REQ-007 SHALL have port spi_copi_i, input, 1, controller-out data, asynchronous.
REQ-008 SHALL have port spi_cipo_o, output, 1, target-out data.
REQ-009 SHALL have port spi_cipo_en_o, output, 1, CIPO output enable for the padring.
REQ-010 SHALL have ports tx_data_i (input, 8), tx_valid_i (input, 1) and tx_ready_o (output, 1), forming the transmit byte handshake.
REQ-011 SHALL have ports rx_data_o (output, 8), rx_valid_o (output, 1) and rx_ready_i (input, 1), forming the receive byte interface.
REQ-012 SHALL have ports tx_underrun_o, rx_overflow_o and frame_end_o, each output, 1, each a single-cycle event pulse.

Function
REQ-013 SHALL operate in SPI mode 0 (CPOL=0, CPHA=0), MSB first, with 8-bit bytes.
REQ-014 SHALL pass each of spi_sclk_i, spi_cs_ni and spi_copi_i through a SyncStages-flop synchroniser, and SHALL edge-detect the synchronised SCLK and CS against a registered copy.
REQ-015 SHALL support SCLK frequencies up to clk_sys_i/8; behaviour at higher SCLK rates is undefined.
REQ-016 SHALL implement the state machine IDLE -> SELECTED on synchronised CS falling edge, and SELECTED -> IDLE on synchronised CS rising edge or reset.
REQ-017 SHALL ignore SCLK edges while in IDLE.
REQ-018 SHALL, on each synchronised SCLK rising edge in SELECTED, shift the synchronised COPI into the LSB of an 8-bit receive shift register and increment a 3-bit bit counter modulo 8.
REQ-019 SHALL, when the counter wraps from 7 to 0, transfer the receive shift register to rx_data_o and assert rx_valid_o in the following cycle.
REQ-020 SHALL hold tx_ready_o high while the 1-entry transmit holding register is empty, and SHALL accept a byte when tx_valid_i && tx_ready_o.
REQ-021 SHALL load the transmit shift register at each byte boundary, meaning the IDLE->SELECTED transition or the first SCLK falling edge after a counter wrap.
REQ-022 SHALL load from the holding register at a byte boundary when it is full and then empty it; otherwise it SHALL load IdleByte and pulse tx_underrun_o.
REQ-023 SHALL, on a byte-boundary load cycle coinciding with a tx accept into an empty holding register, still count an underrun; the accepted byte serves the next byte.
REQ-024 SHALL drive spi_cipo_o from the transmit shift register MSB and shift it left on each non-boundary synchronised SCLK falling edge in SELECTED.
REQ-025 SHALL drive spi_cipo_en_o high only in SELECTED.
REQ-026 SHALL, on CS deassertion mid-byte, discard the partial receive byte (no rx_valid_o), clear the bit counter, and retain the holding register contents.
REQ-027 SHALL pulse frame_end_o for 1 cycle on every SELECTED->IDLE transition.

Reset
REQ-028 SHALL, on rst_sys_ni low at a clk_sys_i edge, enter IDLE, clear the synchronisers to SCLK=0/CS=1/COPI=0, clear the counter and both shift registers, and empty the holding register.
REQ-029 SHALL have output reset values spi_cipo_o=0, spi_cipo_en_o=0, tx_ready_o=1, rx_data_o=0, rx_valid_o=0, tx_underrun_o=0, rx_overflow_o=0, frame_end_o=0.
REQ-030 SHALL, on reset during a transfer, abort it without emitting a frame_end_o pulse.

Configuration
REQ-031 SHALL, with SPI_TARGET_RX_FIFO_EN defined, provide a 4-entry receive FIFO in which rx_valid_o is a level meaning non-empty, rx_ready_i pops it, and rx_data_o shows the head entry.
REQ-032 SHALL, with SPI_TARGET_RX_FIFO_EN defined and the FIFO full, drop a completed byte and pulse rx_overflow_o; a simultaneous pop and push when full SHALL succeed without overflow.
REQ-033 SHALL, without SPI_TARGET_RX_FIFO_EN, assert rx_valid_o as a 1-cycle pulse per byte, ignore rx_ready_i, and tie rx_overflow_o to 0.

Verification
REQ-034 SHALL cover: preload tx 8'hA5, then controller sends 8'h3C at clk_sys_i/8 -> CIPO bits 1,0,1,0,0,1,0,1; rx_data_o=8'h3C with one rx_valid_o.
REQ-035 SHALL cover: no tx preload, 2-byte frame -> CIPO 8'hFF twice; two tx_underrun_o pulses; frame_end_o once at CS rise.
REQ-036 SHALL cover: CS deasserted after 5 SCLK bits -> no rx_valid_o, counter 0, and the next frame receives 8'h81 correctly.
REQ-037 SHALL cover: FIFO enabled with rx_ready_i=0 and 5 bytes sent -> 4 stored in order; rx_overflow_o pulses once on byte 5.
REQ-038 SHALL cover: rst_sys_ni low during bit 3 -> all outputs at their reset values the next cycle; no frame_end_o.
REQ-039 SHALL cover: tx_valid_i asserted in the CS-assert load cycle with an empty holding register -> underrun for byte 0; the accepted byte is sent as byte 1.

Source files
------------

// File: rtl/spi_target.sv
// SPI mode-0 target with synchronised pin inputs, 1-entry tx holding register and byte rx output.
// Define SPI_TARGET_RX_FIFO_EN to replace the rx pulse output with a 4-entry level-valid FIFO.
module spi_target #(
   parameter logic [7:0]  IdleByte   = 8'hFF,
   parameter int unsigned SyncStages = 2
) (
   input  logic       clk_sys_i,
   input  logic       rst_sys_ni,
   input  logic       spi_sclk_i,
   input  logic       spi_cs_ni,
   input  logic       spi_copi_i,
   output logic       spi_cipo_o,
   output logic       spi_cipo_en_o,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   input  logic       rx_ready_i,
   output logic       tx_underrun_o,
   output logic       rx_overflow_o,
   output logic       frame_end_o
);

   typedef enum logic {IDLE, SELECTED} state_e;
   state_e state, state_next;

   logic [SyncStages-1:0] sclk_sync, cs_sync, copi_sync;
   logic sclk_s, cs_s, copi_s, sclk_q, cs_q;
   logic sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic start, stop, active, rise_act, fall_act;
   logic byte_done, load, shift, accept;
   logic [2:0] bit_cnt;
   logic       wrap_pend;
   logic [7:0] rx_shift, tx_shift, hold_data, rx_byte;
   logic       hold_full;

   always_ff @(posedge clk_sys_i) begin
      if (!rst_sys_ni) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         copi_sync <= '0;
         sclk_q    <= 1'b0;
         cs_q      <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SyncStages-2:0], spi_sclk_i};
         cs_sync   <= {cs_sync[SyncStages-2:0], spi_cs_ni};
         copi_sync <= {copi_sync[SyncStages-2:0], spi_copi_i};
         sclk_q    <= sclk_s;
         cs_q      <= cs_s;
      end
   end

   assign sclk_s    = sclk_sync[SyncStages-1];
   assign cs_s      = cs_sync[SyncStages-1];
   assign copi_s    = copi_sync[SyncStages-1];
   assign sclk_rise = sclk_s & ~sclk_q;
   assign sclk_fall = ~sclk_s & sclk_q;
   assign cs_rise   = cs_s & ~cs_q;
   assign cs_fall   = ~cs_s & cs_q;

   always_ff @(posedge clk_sys_i) begin
      if (!rst_sys_ni) state <= IDLE;
      else             state <= state_next;
   end

   always_comb begin
      state_next = state;
      start      = 1'b0;
      stop       = 1'b0;
      case (state)
         IDLE:     if (cs_fall) begin state_next = SELECTED; start = 1'b1; end
         SELECTED: if (cs_rise) begin state_next = IDLE;     stop  = 1'b1; end
         default:  state_next = IDLE;
      endcase
   end

   // CS rise takes priority over any SCLK edge seen in the same cycle
   assign active    = (state == SELECTED) && !cs_rise;
   assign rise_act  = active && sclk_rise;
   assign fall_act  = active && sclk_fall;
   assign byte_done = rise_act && (bit_cnt == 3'd7);
   assign load      = start || (fall_act && wrap_pend);
   assign shift     = fall_act && !wrap_pend;
   assign accept    = tx_valid_i && !hold_full;
   assign rx_byte   = {rx_shift[6:0], copi_s};

   always_ff @(posedge clk_sys_i) begin
      if (!rst_sys_ni) begin
         bit_cnt       <= '0;
         wrap_pend     <= 1'b0;
         rx_shift      <= '0;
         tx_shift      <= '0;
         hold_data     <= '0;
         hold_full     <= 1'b0;
         tx_underrun_o <= 1'b0;
         frame_end_o   <= 1'b0;
      end else begin
         tx_underrun_o <= load && !hold_full;
         frame_end_o   <= stop;
         if (stop) begin
            bit_cnt   <= '0;
            wrap_pend <= 1'b0;
            rx_shift  <= '0;
         end else if (rise_act) begin
            rx_shift <= rx_byte;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) wrap_pend <= 1'b1;
         end
         // A byte accepted in a load cycle lands in the holding register for the next byte
         if (load) begin
            tx_shift  <= hold_full ? hold_data : IdleByte;
            wrap_pend <= 1'b0;
         end else if (shift) begin
            tx_shift <= {tx_shift[6:0], 1'b0};
         end
         if (accept) begin
            hold_data <= tx_data_i;
            hold_full <= 1'b1;
         end else if (load && hold_full) begin
            hold_full <= 1'b0;
         end
      end
   end

   assign spi_cipo_o    = tx_shift[7];
   assign spi_cipo_en_o = (state == SELECTED);
   assign tx_ready_o    = !hold_full;

`ifdef SPI_TARGET_RX_FIFO_EN
   logic [3:0][7:0] fifo_mem;
   logic [1:0]      wr_ptr, rd_ptr;
   logic [2:0]      count;
   logic            fifo_full, pop, do_push;

   assign fifo_full = (count == 3'd4);
   assign pop       = rx_ready_i && (count != 3'd0);
   assign do_push   = byte_done && (!fifo_full || pop);

   always_ff @(posedge clk_sys_i) begin
      if (!rst_sys_ni) begin
         fifo_mem      <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         rx_overflow_o <= 1'b0;
      end else begin
         rx_overflow_o <= byte_done && fifo_full && !pop;
         if (do_push) begin
            fifo_mem[wr_ptr] <= rx_byte;
            wr_ptr           <= wr_ptr + 2'd1;
         end
         if (pop) rd_ptr <= rd_ptr + 2'd1;
         count <= count + {2'b00, do_push} - {2'b00, pop};
      end
   end

   assign rx_data_o  = fifo_mem[rd_ptr];
   assign rx_valid_o = (count != 3'd0);
`else
   logic unused_rx_ready;
   assign unused_rx_ready = rx_ready_i;

   always_ff @(posedge clk_sys_i) begin
      if (!rst_sys_ni) begin
         rx_data_o  <= '0;
         rx_valid_o <= 1'b0;
      end else begin
         rx_valid_o <= byte_done;
         if (byte_done) rx_data_o <= rx_byte;
      end
   end

   assign rx_overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: SPI controller model at clk/8, rx scoreboard, event counters.
module tb_spi_target;

`ifdef SPI_TARGET_RX_FIFO_EN
   localparam bit Fifo = 1'b1;
`else
   localparam bit Fifo = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n, sclk, cs_n, copi, cipo, cipo_en;
   logic [7:0] tx_data, rx_data;
   logic       tx_valid, tx_ready, rx_valid, rx_ready;
   logic       tx_underrun, rx_overflow, frame_end;

   int checks = 0;
   int errors = 0;
   int n_underrun = 0;
   int n_overflow = 0;
   int n_frame_end = 0;
   int n_rx = 0;
   logic [7:0] rx_q[$];

   spi_target #(.IdleByte(8'hFF), .SyncStages(2)) dut (
      .clk_sys_i    (clk),
      .rst_sys_ni   (rst_n),
      .spi_sclk_i   (sclk),
      .spi_cs_ni    (cs_n),
      .spi_copi_i   (copi),
      .spi_cipo_o   (cipo),
      .spi_cipo_en_o(cipo_en),
      .tx_data_i    (tx_data),
      .tx_valid_i   (tx_valid),
      .tx_ready_o   (tx_ready),
      .rx_data_o    (rx_data),
      .rx_valid_o   (rx_valid),
      .rx_ready_i   (rx_ready),
      .tx_underrun_o(tx_underrun),
      .rx_overflow_o(rx_overflow),
      .frame_end_o  (frame_end)
   );

   always #5 clk = ~clk;

   // Event counters and rx scoreboard, sampled on the inactive edge
   always @(negedge clk) begin
      if (tx_underrun) n_underrun++;
      if (rx_overflow) n_overflow++;
      if (frame_end)   n_frame_end++;
      if (rx_valid && (rx_ready || !Fifo)) begin
         n_rx++;
         checks++;
         if (rx_q.size() == 0) begin
            errors++;
            $display("FAIL rx_unexpected: got %h, expected no byte", rx_data);
         end else begin
            logic [7:0] exp;
            exp = rx_q.pop_front();
            if (rx_data !== exp) begin
               errors++;
               $display("FAIL rx_data: got %h, expected %h", rx_data, exp);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cs_assert();
      cs_n = 1'b0;
      wait_clks(4);
   endtask

   // Controller raises CS while SCLK is still high, then parks SCLK low
   task automatic cs_release();
      wait_clks(4);
      cs_n = 1'b1;
      wait_clks(4);
      sclk = 1'b0;
      wait_clks(4);
   endtask

   task automatic xfer_byte(input logic [7:0] mosi, input logic [7:0] miso_exp,
                            input bit push_rx, input bit last, input string tag);
      logic [7:0] got;
      logic       en_ok;
      got   = '0;
      en_ok = 1'b1;
      if (push_rx) rx_q.push_back(mosi);
      for (int i = 7; i >= 0; i--) begin
         copi = mosi[i];
         wait_clks(4);
         got[i] = cipo;
         en_ok  = en_ok & cipo_en;
         sclk   = 1'b1;
         if (!(last && i == 0)) begin
            wait_clks(4);
            sclk = 1'b0;
         end
      end
      checks++;
      if (got !== miso_exp || en_ok !== 1'b1) begin
         errors++;
         $display("FAIL cipo_%s: got %h en %b, expected %h en 1", tag, got, en_ok, miso_exp);
      end
   endtask

   task automatic tx_push(input logic [7:0] d);
      int t = 0;
      while (!tx_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (!tx_ready) begin
         errors++;
         $display("FAIL tx_push_timeout: tx_ready %b, expected 1", tx_ready);
      end else begin
         tx_data  = d;
         tx_valid = 1'b1;
         @(negedge clk);
         tx_valid = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; copi = 1'b0;
      tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b1;
      wait_clks(5);
      checks++;
      if ({cipo, cipo_en, tx_ready, rx_data, rx_valid, tx_underrun, rx_overflow, frame_end}
          !== {1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_outputs: got %b %b %b %h %b %b %b %b, expected 0 0 1 00 0 0 0 0",
                  cipo, cipo_en, tx_ready, rx_data, rx_valid, tx_underrun, rx_overflow, frame_end);
      end
      rst_n = 1'b1;
      wait_clks(6);
   endtask

   task automatic test_basic();
      int u0 = n_underrun;
      int f0 = n_frame_end;
      int r0 = n_rx;
      tx_push(8'hA5);
      checks++;
      if (tx_ready !== 1'b0) begin
         errors++;
         $display("FAIL basic_hold_full: tx_ready %b, expected 0", tx_ready);
      end
      cs_assert();
      xfer_byte(8'h3C, 8'hA5, 1'b1, 1'b1, "basic");
      cs_release();
      checks++;
      if (n_underrun - u0 != 0 || n_frame_end - f0 != 1 || n_rx - r0 != 1 || tx_ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_events: underrun %0d frame_end %0d rx %0d ready %b, expected 0 1 1 1",
                  n_underrun - u0, n_frame_end - f0, n_rx - r0, tx_ready);
      end
      checks++;
      if (cipo_en !== 1'b0) begin
         errors++;
         $display("FAIL basic_cipo_en_idle: got %b, expected 0", cipo_en);
      end
   endtask

   task automatic test_underrun();
      int u0 = n_underrun;
      int f0 = n_frame_end;
      cs_assert();
      xfer_byte(8'h11, 8'hFF, 1'b1, 1'b0, "underrun0");
      xfer_byte(8'h22, 8'hFF, 1'b1, 1'b1, "underrun1");
      cs_release();
      checks++;
      if (n_underrun - u0 != 2 || n_frame_end - f0 != 1) begin
         errors++;
         $display("FAIL underrun_events: underrun %0d frame_end %0d, expected 2 1",
                  n_underrun - u0, n_frame_end - f0);
      end
   endtask

   task automatic test_abort();
      int r0 = n_rx;
      int f0 = n_frame_end;
      logic [7:0] partial = 8'b1011_0000;
      cs_assert();
      tx_push(8'h5A);
      for (int i = 7; i >= 3; i--) begin
         copi = partial[i];
         wait_clks(4);
         sclk = 1'b1;
         wait_clks(4);
         sclk = 1'b0;
      end
      wait_clks(4);
      cs_n = 1'b1;
      wait_clks(8);
      checks++;
      if (n_rx != r0 || dut.bit_cnt !== 3'd0 || n_frame_end - f0 != 1) begin
         errors++;
         $display("FAIL abort_state: rx %0d bit_cnt %0d frame_end %0d, expected 0 0 1",
                  n_rx - r0, dut.bit_cnt, n_frame_end - f0);
      end
      checks++;
      if (tx_ready !== 1'b0) begin
         errors++;
         $display("FAIL abort_hold_kept: tx_ready %b, expected 0", tx_ready);
      end
      cs_assert();
      xfer_byte(8'h81, 8'h5A, 1'b1, 1'b1, "after_abort");
      cs_release();
   endtask

   task automatic test_tx_in_load_cycle();
      int u0 = n_underrun;
      cs_n = 1'b0;
      wait_clks(2);
      tx_data  = 8'hC3;
      tx_valid = 1'b1;
      wait_clks(1);
      tx_valid = 1'b0;
      checks++;
      if (tx_ready !== 1'b0 || tx_underrun !== 1'b1) begin
         errors++;
         $display("FAIL load_cycle_accept: tx_ready %b underrun %b, expected 0 1", tx_ready, tx_underrun);
      end
      wait_clks(1);
      xfer_byte(8'h00, 8'hFF, 1'b1, 1'b0, "load_cycle0");
      xfer_byte(8'h7E, 8'hC3, 1'b1, 1'b1, "load_cycle1");
      cs_release();
      checks++;
      if (n_underrun - u0 != 1) begin
         errors++;
         $display("FAIL load_cycle_underruns: got %0d, expected 1", n_underrun - u0);
      end
   endtask

`ifdef SPI_TARGET_RX_FIFO_EN
   task automatic test_rx_fifo();
      int o0 = n_overflow;
      int r0 = n_rx;
      logic [7:0] bytes [5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54};
      rx_ready = 1'b0;
      cs_assert();
      for (int k = 0; k < 5; k++)
         xfer_byte(bytes[k], 8'hFF, k < 4, k == 4, "fifo");
      cs_release();
      checks++;
      if (n_overflow - o0 != 1 || rx_valid !== 1'b1 || n_rx != r0) begin
         errors++;
         $display("FAIL fifo_full: overflow %0d valid %b pops %0d, expected 1 1 0",
                  n_overflow - o0, rx_valid, n_rx - r0);
      end
      rx_ready = 1'b1;
      wait_clks(10);
      checks++;
      if (n_rx - r0 != 4 || rx_valid !== 1'b0) begin
         errors++;
         $display("FAIL fifo_drain: pops %0d valid %b, expected 4 0", n_rx - r0, rx_valid);
      end
   endtask
`else
   task automatic test_rx_pulse();
      int o0 = n_overflow;
      int r0 = n_rx;
      rx_ready = 1'b0;
      cs_assert();
      xfer_byte(8'h6D, 8'hFF, 1'b1, 1'b1, "rx_pulse");
      cs_release();
      rx_ready = 1'b1;
      checks++;
      if (n_rx - r0 != 1 || n_overflow != o0) begin
         errors++;
         $display("FAIL rx_pulse: rx %0d overflow %0d, expected 1 0", n_rx - r0, n_overflow - o0);
      end
   endtask
`endif

   task automatic test_reset_mid_transfer();
      int f0 = n_frame_end;
      int r0 = n_rx;
      logic [7:0] partial = 8'b0101_0000;
      cs_assert();
      tx_push(8'h99);
      for (int i = 7; i >= 5; i--) begin
         copi = partial[i];
         wait_clks(4);
         sclk = 1'b1;
         wait_clks(4);
         sclk = 1'b0;
      end
      copi = partial[4];
      wait_clks(4);
      sclk = 1'b1;
      wait_clks(2);
      rst_n = 1'b0;
      wait_clks(1);
      checks++;
      if ({cipo, cipo_en, tx_ready, rx_data, rx_valid, tx_underrun, rx_overflow, frame_end}
          !== {1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL midreset_outputs: got %b %b %b %h %b %b %b %b, expected 0 0 1 00 0 0 0 0",
                  cipo, cipo_en, tx_ready, rx_data, rx_valid, tx_underrun, rx_overflow, frame_end);
      end
      cs_n = 1'b1;
      sclk = 1'b0;
      wait_clks(6);
      rst_n = 1'b1;
      wait_clks(8);
      checks++;
      if (n_frame_end != f0 || n_rx != r0 || cipo_en !== 1'b0) begin
         errors++;
         $display("FAIL midreset_events: frame_end %0d rx %0d cipo_en %b, expected 0 0 0",
                  n_frame_end - f0, n_rx - r0, cipo_en);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_underrun();
      test_abort();
      test_tx_in_load_cycle();
`ifdef SPI_TARGET_RX_FIFO_EN
      test_rx_fifo();
`else
      test_rx_pulse();
`endif
      test_reset_mid_transfer();
      wait_clks(4);
      checks++;
      if (rx_q.size() != 0) begin
         errors++;
         $display("FAIL rx_missing: %0d bytes never delivered, expected 0", rx_q.size());
      end
      checks++;
      if (n_overflow != (Fifo ? 1 : 0)) begin
         errors++;
         $display("FAIL overflow_total: got %0d, expected %0d", n_overflow, Fifo ? 1 : 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
